writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Consumes the memory stage's packed 20-bit result word `{is_store, value[15:0], rd[2:0]}` and writes the value into an 8 x 16 architectural register file.
- Serves two combinational read ports to decode, with same-cycle write bypass.
- Keeps a per-register pending scoreboard so decode can stall on RAW hazards until the producing instruction retires.

Parameters:
- DW, 16, register/data width
- NREGS, 8, number of architectural registers (R0 hardwired to zero)
- AW, 3, register index width (log2 NREGS)
- CNT_W, 32, width of the retire/store counters (optional feature only)

Ports:
- clk  input  1  pipeline clock, rising-edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- wb_valid  input  1  rdvalmem carries a real retiring instruction this cycle
- rdvalmem  input  DW+AW+1  packed result from memory stage: bit[19] is_store, [18:3] value, [2:0] rd
- mark_valid  input  1  decode issues an instruction that will write mark_rd
- mark_rd  input  AW  destination register being issued
- rs1_addr  input  AW  read port 1 index
- rs2_addr  input  AW  read port 2 index
- rs1_data  output  DW  read port 1 data (combinational)
- rs2_data  output  DW  read port 2 data (combinational)
- rs1_busy  output  1  pending bit of rs1_addr after bypass
- rs2_busy  output  1  pending bit of rs2_addr after bypass
- wb_done  output  1  registered pulse: a register write retired last cycle
- wb_rd  output  AW  registered index of last retired write

Behaviour:
- Reset (reset==0, asynchronous):
  - all registers = 0, pending[] = 0, wb_done = 0, wb_rd = 0.
  - rs*_data read 0 and rs*_busy read 0 while reset is held.
  - A write in flight when reset asserts is lost.
- Decode of rdvalmem:
  - is_store = [19], wval = [18:3], wrd = [2:0].
  - do_write = wb_valid & ~is_store & (wrd != 0).
- Write (rising edge, do_write): regs[wrd] <= wval.
  - Store retirements (is_store=1) never write; the value field is ignored.
  - Writes to R0 are discarded; R0 always reads 0.
- Reads (combinational):
  - rsN_data = 0 if rsN_addr==0.
  - Else wval if do_write & wrd==rsN_addr (bypass).
  - Else regs[rsN_addr].
  - Write-then-read latency is 0 cycles.
- Scoreboard pending[NREGS]:
  - Set on mark_valid & mark_rd!=0.
  - Cleared on do_write for wrd.
  - Same register set and cleared in the same cycle: set wins (the newer producer is outstanding).
  - pending[0] is constant 0.
  - rsN_busy = pending[rsN_addr] & ~(do_write & wrd==rsN_addr).
  - A clear for a register not pending is harmless (stays 0).
- wb_done/wb_rd:
  - Registered one cycle after do_write: wb_done <= do_write, and wb_rd <= wrd when do_write.
  - wb_rd holds its value otherwise.
- Back-to-back writes to the same rd on consecutive cycles: the last one wins; each pulses wb_done.
- No backpressure: every valid input retires in its cycle; the stage never stalls.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds outputs retire_cnt[CNT_W-1:0] and store_cnt[CNT_W-1:0].
  - retire_cnt increments on every wb_valid.
  - store_cnt increments on wb_valid & is_store.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- Undefined: neither the ports nor the logic exist; all other behaviour is identical.

Decomposition:
- Shared package `wb_pkg`:
  - localparams DW, AW, NREGS and the packed-field positions (IS_STORE_BIT=19, VAL_MSB=18, VAL_LSB=3, RD_MSB=2, RD_LSB=0).
  - The same package is used by memory_unit's producer side.
- One natural sub-module: `wb_scoreboard`, which holds the pending bits with set/clear priority and the busy lookup. It is instantiated once; the register array and bypass stay in the top.

Test Plan:
- Reset: assert reset=0 mid-run after writing R3=0x1234 -> rs1_addr=3 reads 0x0000, rs1_busy=0, wb_done=0; after release, R3 still reads 0.
- Write plus bypass: wb_valid=1, rdvalmem={1'b0,16'hBEEF,3'd5}, rs1_addr=5 in the same cycle -> rs1_data=0xBEEF combinationally; next cycle wb_done=1, wb_rd=5, and R5 reads 0xBEEF from the array.
- Store/R0 suppression:
  - rdvalmem={1'b1,16'hFFFF,3'd2} -> R2 unchanged, wb_done=0.
  - rdvalmem={1'b0,16'h00AA,3'd0} -> R0 reads 0, wb_done=0.
- Scoreboard: mark_valid=1, mark_rd=4 -> rs2_addr=4 busy=1 next cycle.
  - The writeback to R4 clears pending, and busy=0 in the writeback cycle via bypass.
  - Simultaneous mark_rd=4 and writeback rd=4 -> busy remains 1 afterwards.
- Back-to-back: writes R1=0x0001 then R1=0x0002 on consecutive cycles -> R1=0x0002; wb_done high two cycles.
- WB_RETIRE_CNT_EN build: 3 ALU retirements plus 2 stores -> retire_cnt=5, store_cnt=2; preload retire_cnt near 2^CNT_W-1 via force -> wraps to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and packed result-word layout between memory and writeback stages.
package wb_pkg;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NREGS = 8;
  localparam int CNT_W = 32;
  localparam int WORD_W = DW + AW + 1;
  localparam int IS_STORE_BIT = 19;
  localparam int VAL_MSB = 18;
  localparam int VAL_LSB = 3;
  localparam int RD_MSB = 2;
  localparam int RD_LSB = 0;
  typedef struct packed {
    logic          is_store;
    logic [DW-1:0] val;
    logic [AW-1:0] rd;
  } wb_word_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending bits (set beats clear) with bypass-aware busy lookup.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          set_valid_i,
  input  logic [AW-1:0] set_rd_i,
  input  logic          clr_valid_i,
  input  logic [AW-1:0] clr_rd_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o
);
  logic [NREGS-1:0] pending_q, pending_d, set_m, clr_m;
  always_comb begin
    set_m = (set_valid_i && set_rd_i != '0) ? {{(NREGS-1){1'b0}}, 1'b1} << set_rd_i : '0;
    clr_m = clr_valid_i ? {{(NREGS-1){1'b0}}, 1'b1} << clr_rd_i : '0;
    pending_d = ((pending_q & ~clr_m) | set_m) & {{(NREGS-1){1'b1}}, 1'b0};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pending_q <= '0;
    else pending_q <= pending_d;
  assign rs1_busy_o = pending_q[rs1_addr_i] & ~(clr_valid_i && clr_rd_i == rs1_addr_i);
  assign rs2_busy_o = pending_q[rs2_addr_i] & ~(clr_valid_i && clr_rd_i == rs2_addr_i);
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: 8x16 register file write stage with read bypass and RAW scoreboard.
// Define WB_RETIRE_CNT_EN to add retire_cnt/store_cnt counters.
module writeback_unit
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [WORD_W-1:0] rdvalmem,
  input  logic              mark_valid,
  input  logic [AW-1:0]     mark_rd,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DW-1:0]     rs1_data,
  output logic [DW-1:0]     rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              wb_done,
  output logic [AW-1:0]     wb_rd
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  store_cnt
`endif
);
  wb_word_t      w;
  logic          do_write;
  logic [DW-1:0] regs_q [NREGS];
  logic          wb_done_q;
  logic [AW-1:0] wb_rd_q;
  assign w = rdvalmem;
  // gating with reset keeps the bypass from leaking a lost in-flight write
  assign do_write = reset & wb_valid & ~w.is_store & (w.rd != '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wb_done_q <= 1'b0;
      wb_rd_q <= '0;
    end else begin
      if (do_write) regs_q[w.rd] <= w.val;
      if (do_write) wb_rd_q <= w.rd;
      wb_done_q <= do_write;
    end
  assign rs1_data = (rs1_addr == '0) ? '0 : (do_write && w.rd == rs1_addr) ? w.val : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : (do_write && w.rd == rs2_addr) ? w.val : regs_q[rs2_addr];
  assign wb_done = wb_done_q;
  assign wb_rd = wb_rd_q;
  wb_scoreboard u_sb (
    .clk(clk),
    .reset(reset),
    .set_valid_i(mark_valid),
    .set_rd_i(mark_rd),
    .clr_valid_i(do_write),
    .clr_rd_i(w.rd),
    .rs1_addr_i(rs1_addr),
    .rs2_addr_i(rs2_addr),
    .rs1_busy_o(rs1_busy),
    .rs2_busy_o(rs2_busy)
  );
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, store_cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      retire_cnt_q <= '0;
      store_cnt_q <= '0;
    end else begin
      if (wb_valid) retire_cnt_q <= retire_cnt_q + 1'b1;
      if (wb_valid && w.is_store) store_cnt_q <= store_cnt_q + 1'b1;
    end
  assign retire_cnt = retire_cnt_q;
  assign store_cnt = store_cnt_q;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard bench; level checks and retire pulses are queued at stimulus time.
module tb_writeback_unit;
  logic        clk = 0;
  logic        reset = 0;
  logic        wb_valid = 0;
  logic [19:0] rdvalmem = '0;
  logic        mark_valid = 0;
  logic [2:0]  mark_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [15:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy, wb_done;
  logic [2:0]  wb_rd;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt, store_cnt;
`endif
  writeback_unit dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .rdvalmem(rdvalmem),
    .mark_valid(mark_valid), .mark_rd(mark_rd), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_done(wb_done), .wb_rd(wb_rd)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt), .store_cnt(store_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct { int cyc; int sel; logic [31:0] exp; } chk_t;
  typedef struct { int cyc; logic [2:0] rd; } ret_t;
  chk_t lq[$];
  ret_t rq[$];
  int cyc = 0, checks = 0, failures = 0;
  string nm [8] = '{"rs1_data", "rs2_data", "rs1_busy", "rs2_busy", "wb_done", "wb_rd", "retire_cnt", "store_cnt"};
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] pick(int s);
    case (s)
      0: return {16'h0, rs1_data};
      1: return {16'h0, rs2_data};
      2: return {31'h0, rs1_busy};
      3: return {31'h0, rs2_busy};
      4: return {31'h0, wb_done};
      5: return {29'h0, wb_rd};
`ifdef WB_RETIRE_CNT_EN
      6: return retire_cnt;
      7: return store_cnt;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction
  chk_t c;
  ret_t r;
  always @(negedge clk) begin
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      c = lq.pop_front();
      checks++;
      if (c.cyc != cyc || pick(c.sel) !== c.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", nm[c.sel], c.cyc, pick(c.sel), c.exp);
      end
    end
    if (wb_done) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL wb_pulse cyc=%0d got unexpected pulse rd=%0d exp=none", cyc, wb_rd);
      end else begin
        r = rq.pop_front();
        if (r.cyc != cyc || wb_rd !== r.rd) begin
          failures++;
          $display("FAIL wb_pulse cyc=%0d got rd=%0d exp rd=%0d at cyc=%0d", cyc, wb_rd, r.rd, r.cyc);
        end
      end
    end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
      r = rq.pop_front();
      checks++;
      failures++;
      $display("FAIL wb_pulse cyc=%0d got no pulse exp rd=%0d", cyc, r.rd);
    end
  end
  task automatic drive(input logic wv, input logic st, input logic [15:0] v, input logic [2:0] rd,
                       input logic mv, input logic [2:0] mrd, input logic [2:0] a1, input logic [2:0] a2);
    @(posedge clk); #1;
    wb_valid = wv; rdvalmem = {st, v, rd}; mark_valid = mv; mark_rd = mrd;
    rs1_addr = a1; rs2_addr = a2;
    if (reset && wv && !st && rd != 0) rq.push_back('{cyc + 1, rd});
  endtask
  task automatic idle(input logic [2:0] a1, input logic [2:0] a2);
    drive(0, 0, 16'h0, 3'd0, 0, 3'd0, a1, a2);
  endtask
  task automatic expect_v(input int sel, input logic [31:0] e);
    lq.push_back('{cyc, sel, e});
  endtask
  initial begin
    drive(1, 0, 16'h1111, 3'd1, 1, 3'd1, 3'd1, 3'd1);
    expect_v(0, 0); expect_v(1, 0); expect_v(2, 0); expect_v(4, 0); expect_v(5, 0);
    idle(3'd0, 3'd0);
    reset = 1;
    drive(1, 0, 16'hBEEF, 3'd5, 0, 3'd0, 3'd5, 3'd0);
    expect_v(0, 32'hBEEF); expect_v(1, 0);
    idle(3'd5, 3'd5);
    expect_v(0, 32'hBEEF); expect_v(1, 32'hBEEF); expect_v(4, 1); expect_v(5, 5);
    drive(1, 0, 16'h1111, 3'd2, 0, 3'd0, 3'd2, 3'd0);
    drive(1, 1, 16'hFFFF, 3'd2, 0, 3'd0, 3'd2, 3'd5);
    expect_v(0, 32'h1111); expect_v(1, 32'hBEEF);
    idle(3'd2, 3'd0);
    expect_v(0, 32'h1111); expect_v(4, 0); expect_v(5, 2);
    drive(1, 0, 16'h00AA, 3'd0, 0, 3'd0, 3'd0, 3'd0);
    expect_v(0, 0); expect_v(1, 0);
    idle(3'd0, 3'd0);
    expect_v(0, 0); expect_v(4, 0);
    drive(0, 0, 16'h0, 3'd0, 1, 3'd4, 3'd0, 3'd4);
    expect_v(3, 0);
    idle(3'd4, 3'd4);
    expect_v(2, 1); expect_v(3, 1);
    drive(1, 0, 16'h4444, 3'd4, 0, 3'd0, 3'd0, 3'd4);
    expect_v(3, 0); expect_v(1, 32'h4444);
    idle(3'd0, 3'd4);
    expect_v(3, 0); expect_v(1, 32'h4444);
    drive(0, 0, 16'h0, 3'd0, 1, 3'd4, 3'd0, 3'd4);
    drive(1, 0, 16'h5555, 3'd4, 1, 3'd4, 3'd0, 3'd4);
    expect_v(3, 0); expect_v(1, 32'h5555);
    idle(3'd0, 3'd4);
    expect_v(3, 1); expect_v(1, 32'h5555);
    drive(1, 0, 16'h6666, 3'd4, 0, 3'd0, 3'd0, 3'd4);
    idle(3'd0, 3'd4);
    expect_v(3, 0); expect_v(1, 32'h6666);
    drive(1, 0, 16'h0001, 3'd1, 0, 3'd0, 3'd1, 3'd0);
    expect_v(0, 32'h0001);
    drive(1, 0, 16'h0002, 3'd1, 0, 3'd0, 3'd1, 3'd0);
    expect_v(0, 32'h0002); expect_v(4, 1);
    idle(3'd1, 3'd0);
    expect_v(0, 32'h0002); expect_v(4, 1); expect_v(5, 1);
    drive(1, 0, 16'h1234, 3'd3, 0, 3'd0, 3'd3, 3'd0);
    drive(0, 0, 16'h0, 3'd0, 1, 3'd3, 3'd3, 3'd0);
    expect_v(0, 32'h1234);
    idle(3'd3, 3'd0);
    expect_v(0, 32'h1234); expect_v(2, 1);
    @(posedge clk); #1;
    reset = 0;
    wb_valid = 1; rdvalmem = {1'b0, 16'h7777, 3'd3};
    expect_v(0, 0); expect_v(2, 0); expect_v(4, 0);
    idle(3'd3, 3'd0);
    reset = 1;
    idle(3'd3, 3'd3);
    expect_v(0, 0); expect_v(1, 0); expect_v(2, 0); expect_v(4, 0);
`ifdef WB_RETIRE_CNT_EN
    expect_v(6, 0); expect_v(7, 0);
    drive(1, 0, 16'h0011, 3'd1, 0, 3'd0, 3'd0, 3'd0);
    drive(1, 1, 16'h0022, 3'd2, 0, 3'd0, 3'd0, 3'd0);
    drive(1, 0, 16'h0033, 3'd2, 0, 3'd0, 3'd0, 3'd0);
    drive(1, 1, 16'h0044, 3'd3, 0, 3'd0, 3'd0, 3'd0);
    drive(1, 0, 16'h0055, 3'd3, 0, 3'd0, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    expect_v(6, 5); expect_v(7, 2);
    @(posedge clk); #1;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    wb_valid = 1; rdvalmem = {1'b1, 16'h0, 3'd0};
    idle(3'd0, 3'd0);
    expect_v(6, 0); expect_v(7, 3);
`endif
    idle(3'd0, 3'd0);
    idle(3'd0, 3'd0);
    idle(3'd0, 3'd0);
    if (lq.size() != 0 || rq.size() != 0) begin
      failures++;
      $display("FAIL drain got lq=%0d rq=%0d exp 0 0", lq.size(), rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
